// File: rtl/bus_decoder_mux_pkg.sv
// Shared types and default memory map for the data-bus decoder/response mux.
package bus_decoder_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam int unsigned DEF_ADDR_W   = 32;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_N_SLAVES = 3;

   localparam int unsigned SLV_DMEM  = 0;
   localparam int unsigned SLV_TIMER = 1;
   localparam int unsigned SLV_TBMAN = 2;

   localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
   localparam logic [31:0] DMEM_MASK  = 32'hF000_0000;
   localparam logic [31:0] TIMER_BASE = 32'h8000_1000;
   localparam logic [31:0] TIMER_MASK = 32'hFFFF_F000;
   localparam logic [31:0] TBMAN_BASE = 32'h8000_F000;
   localparam logic [31:0] TBMAN_MASK = 32'hFFFF_F000;

   // $clog2 that never yields a zero-width vector
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_decoder_mux_if.sv
// Core-side and slave-side bus signals of the decoder. The master modport is the
// environment (core plus slave devices); the slave modport is the decoder itself.
interface bus_decoder_mux_if #(
   parameter int unsigned N_SLAVES = 3,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32
);
   logic                         m_req;
   logic                         m_we;
   logic [ADDR_W-1:0]            m_addr;
   logic [DATA_W-1:0]            m_wdata;
   logic [DATA_W-1:0]            m_rdata;
   logic                         m_ready;
   logic                         m_err;
   logic [N_SLAVES-1:0]          s_cs_n;
   logic                         s_we;
   logic [ADDR_W-1:0]            s_addr;
   logic [DATA_W-1:0]            s_wdata;
   logic [N_SLAVES*DATA_W-1:0]   s_rdata;
   logic [N_SLAVES-1:0]          s_ready;

   modport master (
      output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
      input  m_rdata, m_ready, m_err, s_cs_n, s_we, s_addr, s_wdata
   );

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
      output m_rdata, m_ready, m_err, s_cs_n, s_we, s_addr, s_wdata
   );
endinterface

// File: rtl/bus_decoder_mux_region_match.sv
// Combinational base/mask address match; the lowest-index hit wins.
module bus_region_match #(
   parameter int unsigned                   N_SLAVES = 3,
   parameter int unsigned                   ADDR_W   = 32,
   parameter int unsigned                   SEL_W    = 2,
   parameter logic [N_SLAVES*ADDR_W-1:0]    BASE     = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0]    MASK     = '0
) (
   input  logic [ADDR_W-1:0]   addr,
   output logic [N_SLAVES-1:0] hit,
   output logic [N_SLAVES-1:0] onehot,
   output logic [SEL_W-1:0]    idx
);

   always_comb begin
      hit = '0;
      idx = '0;
      for (int i = 0; i < int'(N_SLAVES); i++) begin
         hit[i] = ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]);
      end
      for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
         if (hit[i]) idx = SEL_W'(i);
      end
   end

   // isolate the lowest set bit
   assign onehot = hit & (~hit + N_SLAVES'(1));

endmodule

// File: rtl/bus_decoder_mux.sv
// Address decoder and response mux between the core data port and N slaves.
// Optional error-address capture enabled by defining BUS_ERR_CAPTURE_EN.
module bus_decoder_mux
   import bus_decoder_mux_pkg::*;
#(
   parameter int unsigned                 N_SLAVES   = DEF_N_SLAVES,
   parameter int unsigned                 ADDR_W     = DEF_ADDR_W,
   parameter int unsigned                 DATA_W     = DEF_DATA_W,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE = {TBMAN_BASE, TIMER_BASE, DMEM_BASE},
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_MASK = {TBMAN_MASK, TIMER_MASK, DMEM_MASK},
   parameter int unsigned                 TIMEOUT    = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   bus_decoder_mux_if.slave   bus
`ifdef BUS_ERR_CAPTURE_EN
   ,
   output logic [ADDR_W-1:0]  err_addr,
   output logic               err_flag,
   input  logic               err_clr
`endif
);

   localparam int unsigned SEL_W = clog2_min1(N_SLAVES);
   localparam int unsigned CNT_W = clog2_min1(TIMEOUT + 1);

   state_t              state;
   logic [SEL_W-1:0]    sel;
   logic [CNT_W-1:0]    cnt;

   logic [N_SLAVES-1:0] hit;
   logic [N_SLAVES-1:0] dec_onehot;
   logic [SEL_W-1:0]    dec_idx;
   logic                any_hit;
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_rdata;
   logic                timed_out;
   logic                err_miss;
   logic                err_tmo;

   bus_region_match #(
      .N_SLAVES (N_SLAVES),
      .ADDR_W   (ADDR_W),
      .SEL_W    (SEL_W),
      .BASE     (SLAVE_BASE),
      .MASK     (SLAVE_MASK)
   ) u_match (
      .addr   (bus.m_addr),
      .hit    (hit),
      .onehot (dec_onehot),
      .idx    (dec_idx)
   );

   assign any_hit   = |hit;
   assign sel_ready = bus.s_ready[sel];
   assign sel_rdata = bus.s_rdata[int'(sel)*DATA_W +: DATA_W];
   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
   assign err_miss  = (state == ST_IDLE) && bus.m_req && !any_hit;
   // a ready in the final WAIT cycle takes precedence over the timeout
   assign err_tmo   = (state == ST_WAIT) && !sel_ready && timed_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sel         <= '0;
         cnt         <= '0;
         bus.s_cs_n  <= '1;
         bus.s_we    <= 1'b0;
         bus.s_addr  <= '0;
         bus.s_wdata <= '0;
         bus.m_ready <= 1'b0;
         bus.m_err   <= 1'b0;
         bus.m_rdata <= '0;
      end else begin
         bus.m_ready <= 1'b0;
         bus.m_err   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.m_req && any_hit) begin
                  sel         <= dec_idx;
                  bus.s_we    <= bus.m_we;
                  bus.s_addr  <= bus.m_addr;
                  bus.s_wdata <= bus.m_wdata;
                  bus.s_cs_n  <= ~dec_onehot;
                  cnt         <= '0;
                  state       <= ST_WAIT;
               end else if (err_miss) begin
                  bus.m_ready <= 1'b1;
                  bus.m_err   <= 1'b1;
                  bus.m_rdata <= '0;
                  state       <= ST_ERR;
               end
            end
            ST_WAIT: begin
               if (sel_ready) begin
                  bus.m_rdata <= sel_rdata;
                  bus.m_ready <= 1'b1;
                  bus.s_cs_n  <= '1;
                  state       <= ST_RESP;
               end else if (err_tmo) begin
                  bus.m_ready <= 1'b1;
                  bus.m_err   <= 1'b1;
                  bus.m_rdata <= '0;
                  bus.s_cs_n  <= '1;
                  state       <= ST_ERR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RESP: state <= ST_IDLE;
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef BUS_ERR_CAPTURE_EN
   // sticky fault address; a new error beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_addr <= '0;
         err_flag <= 1'b0;
      end else if (err_miss) begin
         err_addr <= bus.m_addr;
         err_flag <= 1'b1;
      end else if (err_tmo) begin
         err_addr <= bus.s_addr;
         err_flag <= 1'b1;
      end else if (err_clr) begin
         err_flag <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_bus_decoder_mux.sv
// Directed vector bench for bus_decoder_mux, default map plus an overlapping map.
module tb_bus_decoder_mux;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bus_decoder_mux_if #(.N_SLAVES(3), .ADDR_W(32), .DATA_W(32)) bus  ();
   bus_decoder_mux_if #(.N_SLAVES(3), .ADDR_W(32), .DATA_W(32)) bus2 ();

`ifdef BUS_ERR_CAPTURE_EN
   logic [31:0] err_addr, err_addr2;
   logic        err_flag, err_flag2;
   logic        err_clr;
`endif

   bus_decoder_mux #(.TIMEOUT(15)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus)
`ifdef BUS_ERR_CAPTURE_EN
      ,
      .err_addr (err_addr),
      .err_flag (err_flag),
      .err_clr  (err_clr)
`endif
   );

   // slave 1 matches every address; slave 0 must still win on overlap
   bus_decoder_mux #(
      .SLAVE_BASE ({32'h8000_F000, 32'h0000_0000, 32'h1000_0000}),
      .SLAVE_MASK ({32'hFFFF_F000, 32'h0000_0000, 32'hF000_0000}),
      .TIMEOUT    (15)
   ) dut2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus2)
`ifdef BUS_ERR_CAPTURE_EN
      ,
      .err_addr (err_addr2),
      .err_flag (err_flag2),
      .err_clr  (1'b0)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          rdy_s;
      int          rdy_k;
      logic [31:0] rdata;
      int          noise;
      logic [2:0]  exp_cs;
      int          exp_lat;
      int          exp_cs_cnt;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends at a negedge with the DUT idle
   task automatic run_vec(input vec_t v, input int id);
      int cyc, cs_cnt, lat;
      logic done;
      logic [2:0] cs1;
      logic we1;
      logic [31:0] addr1, wdata1;
      string tag;
      tag = $sformatf("v%0d", id);
      cyc = 0; cs_cnt = 0; lat = 0; done = 1'b0;
      cs1 = '1; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      bus.m_req = 1'b1; bus.m_we = v.we; bus.m_addr = v.addr; bus.m_wdata = v.wdata;
      bus.s_ready = '0;
      if (v.noise >= 0) begin
         bus.s_ready[v.noise] = 1'b1;
         bus.s_rdata[v.noise*32 +: 32] = 32'hBAD0_0000;
      end
      while (!done && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin
            cs1 = bus.s_cs_n; we1 = bus.s_we; addr1 = bus.s_addr; wdata1 = bus.s_wdata;
         end
         if (bus.s_cs_n != 3'b111) cs_cnt++;
         if (bus.m_ready) begin
            done = 1'b1;
            lat = cyc;
            chk({tag, " m_err"}, 64'(bus.m_err), 64'(v.exp_err));
            chk({tag, " m_rdata"}, 64'(bus.m_rdata), 64'(v.exp_rdata));
         end
         if (v.rdy_s >= 0) begin
            bus.s_ready[v.rdy_s] = (cyc == v.rdy_k);
            if (cyc == v.rdy_k) bus.s_rdata[v.rdy_s*32 +: 32] = v.rdata;
         end
      end
      chk({tag, " done"}, 64'(done), 64'(1));
      chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
      chk({tag, " cs cycle1"}, 64'(cs1), 64'(v.exp_cs));
      chk({tag, " cs low cycles"}, 64'(cs_cnt), 64'(v.exp_cs_cnt));
      if (v.exp_cs != 3'b111) begin
         chk({tag, " s_we"}, 64'(we1), 64'(v.we));
         chk({tag, " s_addr"}, 64'(addr1), 64'(v.addr));
         chk({tag, " s_wdata"}, 64'(wdata1), 64'(v.wdata));
      end
      bus.m_req = 1'b0;
      bus.s_ready = '0;
      @(negedge clk);
      chk({tag, " m_ready pulse"}, 64'(bus.m_ready), 64'(0));
      chk({tag, " m_rdata hold"}, 64'(bus.m_rdata), 64'(v.exp_rdata));
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{32'h1000_0040, 1'b0, 32'h0,    0,  3, 32'hDEAD_BEEF, -1, 3'b110,  4,  3, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{32'h8000_1004, 1'b1, 32'h5,    1,  1, 32'h0,         -1, 3'b101,  2,  1, 1'b0, 32'h0};
      vecs[2] = '{32'h2000_0000, 1'b0, 32'h0,   -1,  0, 32'h0,         -1, 3'b111,  1,  0, 1'b1, 32'h0};
      vecs[3] = '{32'h8000_F000, 1'b0, 32'h0,   -1,  0, 32'h0,         -1, 3'b011, 16, 15, 1'b1, 32'h0};
      vecs[4] = '{32'h8000_1010, 1'b0, 32'h0,    1,  2, 32'h1234_5678,  0, 3'b101,  3,  2, 1'b0, 32'h1234_5678};
      vecs[5] = '{32'h8000_FFFC, 1'b0, 32'h0,    2, 15, 32'hCAFE_F00D, -1, 3'b011, 16, 15, 1'b0, 32'hCAFE_F00D};
      vecs[6] = '{32'h1FFF_FFFC, 1'b1, 32'hA5A5, 0,  1, 32'h77,        -1, 3'b110,  2,  1, 1'b0, 32'h77};
      vecs[7] = '{32'h8000_2000, 1'b0, 32'h0,   -1,  0, 32'h0,         -1, 3'b111,  1,  0, 1'b1, 32'h0};
      vecs[8] = '{32'h1000_0100, 1'b0, 32'h0,    1,  1, 32'h99,        -1, 3'b110, 16, 15, 1'b1, 32'h0};

      rst_n = 1'b0;
      bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
      bus.s_rdata = '0; bus.s_ready = '0;
      bus2.m_req = 1'b0; bus2.m_we = 1'b0; bus2.m_addr = '0; bus2.m_wdata = '0;
      bus2.s_rdata = '0; bus2.s_ready = '0;
`ifdef BUS_ERR_CAPTURE_EN
      err_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset s_cs_n", 64'(bus.s_cs_n), 64'(3'b111));
      chk("reset m_ready", 64'(bus.m_ready), 64'(0));
      chk("reset m_err", 64'(bus.m_err), 64'(0));
      chk("reset m_rdata", 64'(bus.m_rdata), 64'(0));
      chk("reset s_we/addr/wdata", {31'(0), bus.s_we, bus.s_addr} | 64'(bus.s_wdata), 64'(0));
`ifdef BUS_ERR_CAPTURE_EN
      chk("reset err_flag", 64'(err_flag), 64'(0));
      chk("reset err_addr", 64'(err_addr), 64'(0));
`endif
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], i);
`ifdef BUS_ERR_CAPTURE_EN
         if (i == 2) chk("err_addr miss", 64'(err_addr), 64'h2000_0000);
         if (i == 3) chk("err_addr timeout", 64'(err_addr), 64'h8000_F000);
         if (i == 4) chk("err_flag sticky", 64'(err_flag), 64'(1));
`endif
      end

`ifdef BUS_ERR_CAPTURE_EN
      chk("err_addr timeout dmem", 64'(err_addr), 64'h1000_0100);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_flag cleared", 64'(err_flag), 64'(0));
      // miss arriving with a clear: the new error must win
      bus.m_req = 1'b1; bus.m_addr = 32'h3000_0000; err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0; bus.m_req = 1'b0;
      chk("err_flag set beats clr", 64'(err_flag), 64'(1));
      chk("err_addr set beats clr", 64'(err_addr), 64'h3000_0000);
      @(negedge clk);
`endif

      // reset while a TBMAN access is waiting
      bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_addr = 32'h8000_F010; bus.m_wdata = 32'h44;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre-reset cs low", 64'(bus.s_cs_n), 64'(3'b011));
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid reset s_cs_n", 64'(bus.s_cs_n), 64'(3'b111));
      chk("mid reset m_ready", 64'(bus.m_ready), 64'(0));
      chk("mid reset m_rdata", 64'(bus.m_rdata), 64'(0));
      chk("mid reset s_addr", 64'(bus.s_addr), 64'(0));
      rst_n = 1'b1; bus.m_req = 1'b0; bus.m_we = 1'b0;
      @(negedge clk);
      run_vec(vecs[0], 90);

      // overlapping map: slave 0 wins, slave 1 ready ignored
      bus2.m_req = 1'b1; bus2.m_addr = 32'h1000_0000;
      bus2.s_rdata = {32'h0, 32'h0000_0BAD, 32'h0000_5A5A};
      bus2.s_ready = 3'b010;
      @(posedge clk); @(negedge clk);
      chk("ovl cs", 64'(bus2.s_cs_n), 64'(3'b110));
      @(posedge clk); @(negedge clk);
      chk("ovl slave1 ready ignored", 64'(bus2.m_ready), 64'(0));
      bus2.s_ready = 3'b011;
      @(posedge clk); @(negedge clk);
      chk("ovl m_ready", 64'(bus2.m_ready), 64'(1));
      chk("ovl m_rdata", 64'(bus2.m_rdata), 64'h5A5A);
      chk("ovl m_err", 64'(bus2.m_err), 64'(0));
      bus2.m_req = 1'b0; bus2.s_ready = '0;
      @(negedge clk);
      bus2.m_req = 1'b1; bus2.m_addr = 32'h2000_0000;
      @(posedge clk); @(negedge clk);
      chk("ovl catch-all cs", 64'(bus2.s_cs_n), 64'(3'b101));
      bus2.s_ready = 3'b010;
      @(posedge clk); @(negedge clk);
      chk("ovl catch-all rdata", 64'(bus2.m_rdata), 64'h0BAD);
      bus2.m_req = 1'b0; bus2.s_ready = '0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
